// File: rtl/ariane_pkg.sv
// ariane_pkg: shared fetch-control types and defaults.
package ariane_pkg;
   localparam int unsigned FETCH_BYTES_DEF = 4;
   typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, KILL, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_credit_cnt.sv
// fetch_credit_cnt: free instruction-queue groups minus the outstanding fetch request.
module fetch_credit_cnt #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          dec_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic [CW-1:0] cnt_nxt_o
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [CW-1:0] cnt_q;
   assign cnt_o = cnt_q;
   assign cnt_nxt_o = load_i ? FULL
                    : (inc_i && !dec_i) ? ((cnt_q == FULL) ? FULL : cnt_q + 1'b1)
                    : (dec_i && !inc_i) ? cnt_q - 1'b1
                    : cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= FULL;
      else cnt_q <= cnt_nxt_o;
   end
   // a pop with every group already free means the queue and this counter disagree
   always_ff @(posedge clk_i) begin
      if (!rst_i && !load_i && inc_i && !dec_i)
         assert (cnt_q != FULL) else $error("fetch_credit_cnt: pop with full credits");
   end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencing, icache request handshake and IQ push under credit flow control.
// Defining FETCH_CTRL_PERF_EN adds a saturating count of zero-credit IDLE cycles on perf_stall_cnt_o.
module fetch_ctrl
   import ariane_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] boot_addr_i,
   input  logic        flush_i,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_addr_i,
   output logic        icache_req_valid_o,
   input  logic        icache_req_ready_i,
   output logic [63:0] icache_req_addr_o,
   output logic        icache_kill_o,
   input  logic        icache_rsp_valid_i,
   input  logic        icache_rsp_ex_i,
   input  logic        predict_taken_i,
   input  logic [63:0] predict_addr_i,
   output logic        iq_push_o,
   output logic        iq_ex_o,
   output logic [63:0] iq_base_addr_o,
   input  logic        iq_pop_i,
   output logic        iq_ready_o,
   output logic [31:0] perf_stall_cnt_o
);
   localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
   localparam logic [63:0] GRP_MASK = 64'(FETCH_BYTES - 1);
   fetch_state_e  state_q, state_d;
   logic [63:0]   fetch_pc_q;
   logic [CW-1:0] credits, credits_nxt;
   logic          fl, req_fire, rsp_fire;
   assign fl = flush_i | redirect_valid_i;
   assign req_fire = icache_req_valid_o & icache_req_ready_i;
   assign rsp_fire = ~rst_i & ~fl & (state_q == WAIT_RSP) & icache_rsp_valid_i;
   fetch_credit_cnt #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_credit (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (fl),
      .dec_i     (req_fire),
      .inc_i     (iq_pop_i),
      .cnt_o     (credits),
      .cnt_nxt_o (credits_nxt)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) fetch_pc_q <= boot_addr_i;
      else if (redirect_valid_i) fetch_pc_q <= redirect_addr_i;
      else if (rsp_fire) fetch_pc_q <= predict_taken_i ? predict_addr_i
                                                       : (fetch_pc_q & ~GRP_MASK) + 64'(FETCH_BYTES);
   end
   // a flush racing a grant in REQ abandons the just-accepted request through KILL
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = (!fl && credits != '0) ? REQ : IDLE;
         REQ:      state_d = fl ? (icache_req_ready_i ? KILL : IDLE)
                                : (icache_req_ready_i ? WAIT_RSP : REQ);
         WAIT_RSP: state_d = fl ? KILL
                           : !icache_rsp_valid_i ? WAIT_RSP
                           : icache_rsp_ex_i ? HALT
                           : (credits_nxt != '0) ? REQ : IDLE;
         KILL:     state_d = IDLE;
         HALT:     state_d = fl ? IDLE : HALT;
         default:  state_d = IDLE;
      endcase
   end
   always_comb begin
      icache_req_valid_o = ~rst_i & (state_q == REQ);
      icache_req_addr_o = icache_req_valid_o ? fetch_pc_q : '0;
      icache_kill_o = ~rst_i & fl & ((state_q == WAIT_RSP) | ((state_q == REQ) & icache_req_ready_i));
      iq_push_o = rsp_fire;
      iq_ex_o = rsp_fire & icache_rsp_ex_i;
      iq_base_addr_o = rsp_fire ? fetch_pc_q : '0;
      iq_ready_o = ~rst_i & (credits != '0);
   end
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) stall_q <= '0;
      else if (state_q == IDLE && credits == '0 && stall_q != '1) stall_q <= stall_q + 1'b1;
   end
   assign perf_stall_cnt_o = rst_i ? '0 : stall_q;
`else
   assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic checked every cycle
// against a flag-level behavioural model of the fetch controller.
module tb_fetch_ctrl;
   localparam int D  = 4;
   localparam int FB = 4;
   logic        clk = 1'b0;
   logic        rst_i, flush_i, redirect_valid_i, icache_req_ready_i;
   logic        icache_rsp_valid_i, icache_rsp_ex_i, predict_taken_i;
   logic        iq_pop_i = 1'b0;
   logic [63:0] boot_addr_i, redirect_addr_i, predict_addr_i;
   logic        icache_req_valid_o, icache_kill_o, iq_push_o, iq_ex_o, iq_ready_o;
   logic [63:0] icache_req_addr_o, iq_base_addr_o;
   logic [31:0] perf_stall_cnt_o;
   int checks = 0, errors = 0, push_cnt = 0, p0 = 0;
   logic [63:0] m_pc;
   int          m_cred, occ = 0;
   bit          m_req, m_wait, m_halt, m_drop;
   logic [31:0] m_stall;
   bit          pop_en = 0, pop_rand = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.QUEUE_DEPTH(D), .FETCH_BYTES(FB)) dut (
      .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .flush_i(flush_i),
      .redirect_valid_i(redirect_valid_i), .redirect_addr_i(redirect_addr_i),
      .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
      .icache_req_addr_o(icache_req_addr_o), .icache_kill_o(icache_kill_o),
      .icache_rsp_valid_i(icache_rsp_valid_i), .icache_rsp_ex_i(icache_rsp_ex_i),
      .predict_taken_i(predict_taken_i), .predict_addr_i(predict_addr_i),
      .iq_push_o(iq_push_o), .iq_ex_o(iq_ex_o), .iq_base_addr_o(iq_base_addr_o),
      .iq_pop_i(iq_pop_i), .iq_ready_o(iq_ready_o), .perf_stall_cnt_o(perf_stall_cnt_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic expect_req(input string nm, input logic [63:0] a);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = icache_req_valid_o;
      end
      if (got) chk(nm, icache_req_addr_o, a);
      else begin checks++; errors++; $display("FAIL %s: no request within 40 cycles", nm); end
   endtask

   task automatic expect_push(input string nm, input logic [63:0] a, input logic ex);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = iq_push_o;
      end
      if (got) begin chk(nm, iq_base_addr_o, a); chk({nm, "_ex"}, iq_ex_o, ex); end
      else begin checks++; errors++; $display("FAIL %s: no push within 40 cycles", nm); end
   endtask

   // downstream queue consumer: only pops groups that are actually held
   always @(posedge clk) begin
      #2 iq_pop_i = pop_en && occ > 0 && (!pop_rand || $urandom_range(1, 0) == 1);
   end

   // reference model: compare this cycle's outputs, then advance to the next cycle
   always @(negedge clk) begin
      logic fl, hs, e_valid, e_kill, e_push, e_ex, e_iqr;
      logic [63:0] e_addr, e_base;
      logic [31:0] e_perf;
      int nc;
      fl = flush_i | redirect_valid_i;
      hs = m_req && icache_req_ready_i;
      if (rst_i) begin
         {e_valid, e_kill, e_push, e_ex, e_iqr} = '0;
         e_addr = '0;
         e_base = '0;
      end else begin
         e_valid = m_req;
         e_addr = m_req ? m_pc : 64'd0;
         e_kill = fl && (m_wait || hs);
         e_push = m_wait && icache_rsp_valid_i && !fl;
         e_base = e_push ? m_pc : 64'd0;
         e_ex = e_push && icache_rsp_ex_i;
         e_iqr = m_cred > 0;
      end
`ifdef FETCH_CTRL_PERF_EN
      e_perf = rst_i ? 32'd0 : m_stall;
`else
      e_perf = 32'd0;
`endif
      chk("m_req_valid", icache_req_valid_o, e_valid);
      chk("m_req_addr", icache_req_addr_o, e_addr);
      chk("m_kill", icache_kill_o, e_kill);
      chk("m_push", iq_push_o, e_push);
      chk("m_base", iq_base_addr_o, e_base);
      chk("m_ex", iq_ex_o, e_ex);
      chk("m_iq_ready", iq_ready_o, e_iqr);
      chk("m_perf", perf_stall_cnt_o, e_perf);
      if (iq_push_o) push_cnt++;
      if (rst_i) begin
         m_pc = boot_addr_i;
         m_cred = D;
         {m_req, m_wait, m_halt, m_drop} = '0;
         occ = 0;
         m_stall = '0;
      end else begin
         if (!(m_req || m_wait || m_halt || m_drop) && m_cred == 0 && m_stall != '1) m_stall++;
         if (fl) begin
            if (redirect_valid_i) m_pc = redirect_addr_i;
            m_cred = D;
            occ = 0;
            m_drop = e_kill;
            {m_req, m_wait, m_halt} = '0;
         end else begin
            occ = occ + (e_push ? 1 : 0) - (iq_pop_i ? 1 : 0);
            nc = m_cred - (hs ? 1 : 0) + (iq_pop_i ? 1 : 0);
            if (nc > D) nc = D;
            if (m_drop) m_drop = 0;
            else if (m_halt) m_halt = 1;
            else if (m_req) begin
               if (icache_req_ready_i) begin m_req = 0; m_wait = 1; end
            end else if (m_wait) begin
               if (icache_rsp_valid_i) begin
                  m_wait = 0;
                  m_pc = predict_taken_i ? predict_addr_i : (m_pc / FB) * FB + FB;
                  if (icache_rsp_ex_i) m_halt = 1;
                  else m_req = nc > 0;
               end
            end else m_req = m_cred > 0;
            m_cred = nc;
         end
      end
   end

   initial begin
      rst_i = 1; boot_addr_i = 64'h8000_0000; flush_i = 0; redirect_valid_i = 0;
      redirect_addr_i = '0; icache_req_ready_i = 1; icache_rsp_valid_i = 1;
      icache_rsp_ex_i = 0; predict_taken_i = 0; predict_addr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_iq_ready", iq_ready_o, 0);
      chk("rst_req_valid", icache_req_valid_o, 0);
      @(posedge clk); #1 rst_i = 0;
      @(negedge clk);
      chk("boot_iq_ready", iq_ready_o, 1);
      chk("boot_idle", icache_req_valid_o, 0);
      p0 = push_cnt;
      for (int i = 0; i < 4; i++) begin
         expect_req($sformatf("seq_req%0d", i), 64'h8000_0000 + 64'(4 * i));
         expect_push($sformatf("seq_push%0d", i), 64'h8000_0000 + 64'(4 * i), 1'b0);
      end
      repeat (3) begin
         @(negedge clk);
         chk("full_no_req", icache_req_valid_o, 0);
         chk("full_iq_ready", iq_ready_o, 0);
      end
      chk("four_pushes", 64'(push_cnt - p0), 4);
      @(posedge clk); #1 pop_en = 1;
      @(posedge clk); #1 pop_en = 0;
      expect_req("req_after_pop", 64'h8000_0010);
      expect_push("push_after_pop", 64'h8000_0010, 1'b0);
      repeat (3) begin @(negedge clk); chk("one_more_only", icache_req_valid_o, 0); end
      @(posedge clk); #1 pop_en = 1;
      expect_req("req14", 64'h8000_0014);
      @(posedge clk); #1 predict_taken_i = 1; predict_addr_i = 64'h8000_1002;
      expect_push("push14", 64'h8000_0014, 1'b0);
      @(posedge clk); #1 predict_taken_i = 0;
      expect_req("req_pred", 64'h8000_1002);
      expect_push("push_pred", 64'h8000_1002, 1'b0);
      @(posedge clk); #1 icache_rsp_valid_i = 0;
      expect_req("req_pred_seq", 64'h8000_1004);
      @(posedge clk); #1 redirect_valid_i = 1; redirect_addr_i = 64'h9000_0000; icache_rsp_valid_i = 1; pop_en = 0;
      @(negedge clk);
      chk("kill_pulse", icache_kill_o, 1);
      chk("kill_no_push", iq_push_o, 0);
      @(posedge clk); #1 redirect_valid_i = 0;
      @(negedge clk);
      chk("kill_once", icache_kill_o, 0);
      chk("late_rsp_dropped", iq_push_o, 0);
      expect_req("req_redirect", 64'h9000_0000);
      chk("credits_after_redirect", 64'(dut.credits), 4);
      expect_push("push_r0", 64'h9000_0000, 1'b0);
      expect_req("req_r1", 64'h9000_0004);
      expect_push("push_r1", 64'h9000_0004, 1'b0);
      expect_req("req_r2", 64'h9000_0008);
      expect_push("push_r2", 64'h9000_0008, 1'b0);
      @(posedge clk); #1 pop_en = 1;
      @(negedge clk);
      chk("req_r3_valid", icache_req_valid_o, 1);
      chk("req_r3_addr", icache_req_addr_o, 64'h9000_000C);
      chk("credits_at_one", 64'(dut.credits), 1);
      @(posedge clk); #1 pop_en = 0; icache_rsp_ex_i = 1;
      @(negedge clk);
      chk("credits_hold", 64'(dut.credits), 1);
      chk("ex_push", iq_push_o, 1);
      chk("ex_flag", iq_ex_o, 1);
      chk("ex_base", iq_base_addr_o, 64'h9000_000C);
      @(posedge clk); #1 icache_rsp_ex_i = 0;
      repeat (10) begin
         @(negedge clk);
         chk("halt_no_req", icache_req_valid_o, 0);
         chk("halt_no_push", iq_push_o, 0);
      end
      @(posedge clk); #1 flush_i = 1;
      @(posedge clk); #1 flush_i = 0;
      expect_req("resume_after_flush", 64'h9000_0010);
      pop_en = 1; pop_rand = 1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         rst_i = $urandom_range(499, 0) == 0;
         if (rst_i) boot_addr_i = {$urandom, $urandom};
         icache_req_ready_i = $urandom_range(3, 0) != 0;
         icache_rsp_valid_i = $urandom_range(2, 0) != 0;
         icache_rsp_ex_i = $urandom_range(24, 0) == 0;
         predict_taken_i = $urandom_range(3, 0) == 0;
         predict_addr_i = ($urandom_range(7, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom};
         flush_i = $urandom_range(39, 0) == 0;
         redirect_valid_i = $urandom_range(39, 0) == 0;
         redirect_addr_i = {$urandom, $urandom};
      end
      @(posedge clk); #1 rst_i = 0; flush_i = 0; redirect_valid_i = 0;
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
